// File: rtl/sobel_detector.sv
// ----------------------------------------------------------------------------
// sobel_detector
//   Streaming 3x3 Sobel edge detector for 8-bit grayscale video. Takes one
//   pixel per clock while per_img_href is high and produces a 1-bit edge map
//   with the input sync timing delayed by a fixed 4-clock pipeline.
//
// Handshake: there is no back-pressure. per_img_href qualifies
//   per_img_gray on every clock it is high. post_img_href qualifies
//   post_img_bit in the same way, exactly 4 clocks later.
//
// Ports
//   clk            : single clock, rising edge
//   rst            : asynchronous active-high reset
//   thresh[7:0]    : edge threshold; an edge needs Gx^2+Gy^2 > thresh^2
//   per_img_vsync  : input frame valid
//   per_img_href   : input pixel valid
//   per_img_gray   : input luminance
//   post_img_vsync : per_img_vsync delayed 4 clocks
//   post_img_href  : per_img_href delayed 4 clocks
//   post_img_bit   : edge flag, meaningful when post_img_href=1, else 0
// ----------------------------------------------------------------------------
module sobel_detector #(
  parameter int IMG_H_DISP = 512,
  parameter int IMG_V_DISP = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] thresh,
  input  logic       per_img_vsync,
  input  logic       per_img_href,
  input  logic [7:0] per_img_gray,
  output logic       post_img_vsync,
  output logic       post_img_href,
  output logic       post_img_bit
);

  localparam int CW = $clog2(IMG_H_DISP);
  localparam int RW = $clog2(IMG_V_DISP);

  // position counters and sync edge tracking
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          vs_q, hs_q;
  logic          armed_q, armed_d;
  logic          frame_q, frame_d;
  logic          sof, href_fall;

  // line buffers: lb1 holds row r-1, lb2 holds row r-2
  logic [7:0] lb1 [IMG_H_DISP];
  logic [7:0] lb2 [IMG_H_DISP];
  logic [7:0] lb1_rd, lb2_rd;

  // win_q[i][j]: i = row (0 top), j = column (0 left)
  logic [2:0][2:0][7:0] win_q;
  logic [3:0]           vs_dly_q, hs_dly_q;
  logic                 v1_q, v2_q, v3_q, v1_d;
  logic signed [10:0]   gx_q, gy_q, gx_d, gy_d;
  logic [9:0]           pos_x, neg_x, pos_y, neg_y;
  logic signed [21:0]   gx_sq, gy_sq;
  logic [20:0]          mag_q, mag_d;
  logic [15:0]          thr_sq;
  logic                 bit_q, bit_d;

  // armed_q is set once vsync has been seen low, so that a reset taken in
  // the middle of a frame does not treat the still-high vsync as a new frame.
  assign sof       = per_img_vsync & ~vs_q & armed_q;
  assign href_fall = hs_q & ~per_img_href;

  always_comb begin
    col_d   = '0;
    row_d   = row_q;
    armed_d = armed_q | ~per_img_vsync;
    frame_d = frame_q;
    if (per_img_href) begin
      col_d = (col_q == CW'(IMG_H_DISP - 1)) ? '0 : col_q + CW'(1);
    end
    if (sof) begin
      row_d = '0;
    end else if (href_fall && row_q != RW'(IMG_V_DISP - 1)) begin
      row_d = row_q + RW'(1);
    end
    if (sof) begin
      frame_d = 1'b1;
    end else if (!per_img_vsync) begin
      frame_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      vs_q    <= 1'b0;
      hs_q    <= 1'b0;
      armed_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      vs_q    <= per_img_vsync;
      hs_q    <= per_img_href;
      armed_q <= armed_d;
      frame_q <= frame_d;
    end
  end

  // Line buffers are not reset; the r<2 rule masks stale history.
  assign lb1_rd = lb1[col_q];
  assign lb2_rd = lb2[col_q];

  always_ff @(posedge clk) begin
    if (per_img_href) begin
      lb1[col_q] <= per_img_gray;
      lb2[col_q] <= lb1_rd;
    end
  end

  // Stage 1 qualifier: complete window inside an accepted frame
  assign v1_d = per_img_href & frame_q & (row_q >= RW'(2)) & (col_q >= CW'(2));

  // Stage 2 terms, each at most 4*255 = 1020
  assign pos_x = {2'b0, win_q[0][2]} + {1'b0, win_q[1][2], 1'b0} + {2'b0, win_q[2][2]};
  assign neg_x = {2'b0, win_q[0][0]} + {1'b0, win_q[1][0], 1'b0} + {2'b0, win_q[2][0]};
  assign pos_y = {2'b0, win_q[2][0]} + {1'b0, win_q[2][1], 1'b0} + {2'b0, win_q[2][2]};
  assign neg_y = {2'b0, win_q[0][0]} + {1'b0, win_q[0][1], 1'b0} + {2'b0, win_q[0][2]};
  assign gx_d  = $signed({1'b0, pos_x}) - $signed({1'b0, neg_x});
  assign gy_d  = $signed({1'b0, pos_y}) - $signed({1'b0, neg_y});

  // Stage 3: each square is <= 1,040,400 so 21 bits hold the sum exactly
  assign gx_sq = gx_q * gx_q;
  assign gy_sq = gy_q * gy_q;
  assign mag_d = gx_sq[20:0] + gy_sq[20:0];

  // Stage 4
  assign thr_sq = thresh * thresh;
  assign bit_d  = v3_q & (mag_q > {5'b0, thr_sq});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q    <= '0;
      vs_dly_q <= '0;
      hs_dly_q <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      gx_q     <= '0;
      gy_q     <= '0;
      mag_q    <= '0;
      bit_q    <= 1'b0;
    end else begin
      if (per_img_href) begin
        for (int i = 0; i < 3; i++) begin
          win_q[i][0] <= win_q[i][1];
          win_q[i][1] <= win_q[i][2];
        end
        win_q[0][2] <= lb2_rd;
        win_q[1][2] <= lb1_rd;
        win_q[2][2] <= per_img_gray;
      end
      vs_dly_q <= {vs_dly_q[2:0], per_img_vsync};
      hs_dly_q <= {hs_dly_q[2:0], per_img_href};
      v1_q     <= v1_d;
      v2_q     <= v1_q;
      v3_q     <= v2_q;
      gx_q     <= gx_d;
      gy_q     <= gy_d;
      mag_q    <= mag_d;
      bit_q    <= bit_d;
    end
  end

  assign post_img_vsync = vs_dly_q[3];
  assign post_img_href  = hs_dly_q[3];
  assign post_img_bit   = bit_q;

endmodule

// File: tb/tb_sobel_detector.sv
module tb_sobel_detector;

  localparam int H = 16;
  localparam int V = 10;

  logic       clk;
  logic       rst;
  logic [7:0] thresh;
  logic       per_img_vsync;
  logic       per_img_href;
  logic [7:0] per_img_gray;
  logic       post_img_vsync;
  logic       post_img_href;
  logic       post_img_bit;

  sobel_detector #(.IMG_H_DISP(H), .IMG_V_DISP(V)) dut (
    .clk            (clk),
    .rst            (rst),
    .thresh         (thresh),
    .per_img_vsync  (per_img_vsync),
    .per_img_href   (per_img_href),
    .per_img_gray   (per_img_gray),
    .post_img_vsync (post_img_vsync),
    .post_img_href  (post_img_href),
    .post_img_bit   (post_img_bit)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [0:0] exp_q[$];
  logic [1:0] hist_q[$];
  int         img [V][H];
  int         n_cmp = 0;
  int         n_err = 0;
  bit         check_bits = 1'b1;
  int         pix_cnt = 0;
  logic       pv_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic exp_bit(input int r, input int c, input int t);
    int p [3][3];
    int gx, gy;
    if (r < 2 || c < 2) return 1'b0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = img[r-2+i][c-2+j];
    gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    return (gx*gx + gy*gy) > (t*t);
  endfunction

  // mode 0 uniform 0x80, 1 vertical step, 2 horizontal step, 3 single pixel, 4 random
  task automatic fill(input int mode);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        case (mode)
          0: img[r][c] = 128;
          1: img[r][c] = (c < 5) ? 0 : 255;
          2: img[r][c] = (r < 4) ? 0 : 200;
          3: img[r][c] = (r == 5 && c == 8) ? 48 : 0;
          default: img[r][c] = int'($urandom_range(0, 255));
        endcase
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input int thr, input bit abort);
    if (!abort) begin
      for (int r = 0; r < V; r++)
        for (int c = 0; c < H; c++)
          exp_q.push_back(exp_bit(r, c, thr));
    end else begin
      check_bits = 1'b0;
    end
    thresh = 8'(thr);
    tick();
    per_img_vsync = 1'b1;
    repeat (2) tick();
    for (int r = 0; r < V; r++) begin
      int nb;
      for (int c = 0; c < H; c++) begin
        tick();
        per_img_href = 1'b1;
        per_img_gray = 8'(img[r][c]);
        if (abort && r == 5 && c == 7) begin
          rst = 1'b1;
          per_img_href = 1'b0;
          per_img_vsync = 1'b0;
          #1;
          chk("rst_mid_vsync", {31'b0, post_img_vsync}, 0);
          chk("rst_mid_href", {31'b0, post_img_href}, 0);
          chk("rst_mid_bit", {31'b0, post_img_bit}, 0);
          repeat (3) tick();
          rst = 1'b0;
          repeat (4) tick();
          check_bits = 1'b1;
          return;
        end
      end
      nb = int'($urandom_range(1, 4));
      tick();
      per_img_href = 1'b0;
      repeat (nb - 1) tick();
    end
    repeat (2) tick();
    per_img_vsync = 1'b0;
    repeat (6) tick();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      hist_q.delete();
    end else begin
      hist_q.push_back({per_img_vsync, per_img_href});
      if (hist_q.size() == 5) begin
        chk("lat_vsync", {31'b0, post_img_vsync}, {31'b0, hist_q[0][1]});
        chk("lat_href", {31'b0, post_img_href}, {31'b0, hist_q[0][0]});
        void'(hist_q.pop_front());
      end
      if (post_img_href) begin
        pix_cnt++;
        if (check_bits) begin
          if (exp_q.size() == 0) chk("exp_underflow", 1, 0);
          else chk("edge_bit", {31'b0, post_img_bit}, {31'b0, exp_q.pop_front()});
        end
      end else begin
        chk("bit_idle", {31'b0, post_img_bit}, 0);
      end
      if (post_img_vsync && !pv_prev) pix_cnt = 0;
      if (!post_img_vsync && pv_prev && check_bits) chk("frame_pixels", pix_cnt, H*V);
    end
    pv_prev = post_img_vsync;
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    thresh = 8'd0;
    per_img_vsync = 1'b0;
    per_img_href = 1'b0;
    per_img_gray = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_vsync", {31'b0, post_img_vsync}, 0);
    chk("reset_href", {31'b0, post_img_href}, 0);
    chk("reset_bit", {31'b0, post_img_bit}, 0);
    rst = 1'b0;
    repeat (4) tick();

    fill(0); drive_frame(96, 1'b0);
    fill(1); drive_frame(96, 1'b0);
    fill(2); drive_frame(255, 1'b0);
    fill(3); drive_frame(96, 1'b0);
    fill(3); drive_frame(95, 1'b0);
    fill(4); drive_frame(int'($urandom_range(0, 255)), 1'b0);
    fill(4); drive_frame(0, 1'b0);
    fill(4); drive_frame(int'($urandom_range(100, 200)), 1'b1);
    fill(4); drive_frame(int'($urandom_range(0, 255)), 1'b0);
    fill(4); drive_frame(int'($urandom_range(0, 255)), 1'b0);

    repeat (8) tick();
    chk("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
